// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding unit.
//   fwd_sel_t : EX operand mux select (register file, MEM/WB, EX/MEM)
//   state_t   : load-use stall sequencer states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding comparator.
//   ars             : EX-stage source register address
//   ard_ex_mem      : MEM-stage destination, regwrite_ex_mem its write enable
//   ard_mem_wb      : WB-stage destination, regwrite_mem_wb its write enable
//   sel             : forwarding select for this operand
// The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ars,
    input  logic [REG_ADDR_W-1:0] ard_ex_mem,
    input  logic                  regwrite_ex_mem,
    input  logic [REG_ADDR_W-1:0] ard_mem_wb,
    input  logic                  regwrite_mem_wb,
    output fwd_sel_t              sel
);

    logic hit_ex_mem;
    logic hit_mem_wb;

    assign hit_ex_mem = regwrite_ex_mem && (ard_ex_mem != '0) && (ard_ex_mem == ars);
    assign hit_mem_wb = regwrite_mem_wb && (ard_mem_wb != '0) && (ard_mem_wb == ars);

    always_comb begin
        sel = FWD_RF;
        if (hit_ex_mem) begin
            sel = FWD_EX_MEM;
        end else if (hit_mem_wb) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard and forwarding unit, placed beside the ID/EX register.
//   clk, rst_n       : clock, asynchronous active-low reset
//   ars_if_id        : decode-stage source addresses, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//   uses_rs_if_id    : decode-stage source valid per operand
//   ars_id_ex        : EX-stage source addresses
//   ard_id_ex, regwrite_id_ex, memread_id_ex : EX-stage destination and control
//   ard_ex_mem, regwrite_ex_mem              : MEM-stage destination and control
//   ard_mem_wb, regwrite_mem_wb              : WB-stage destination and control
//   flush            : branch/jump taken, kills IF/ID
//   forward          : per-operand EX mux select (2 bits per operand)
//   stall_pc, stall_if_id : hold enables
//   bubble_id_ex     : insert NOP into ID/EX
//   stall_cnt        : saturating count of stalled cycles
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ars_if_id,
    input  logic [NUM_SRC-1:0]            uses_rs_if_id,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ars_id_ex,
    input  logic [REG_ADDR_W-1:0]         ard_id_ex,
    input  logic                          regwrite_id_ex,
    input  logic                          memread_id_ex,
    input  logic [REG_ADDR_W-1:0]         ard_ex_mem,
    input  logic                          regwrite_ex_mem,
    input  logic [REG_ADDR_W-1:0]         ard_mem_wb,
    input  logic                          regwrite_mem_wb,
    input  logic                          flush,
    output logic [NUM_SRC*2-1:0]          forward,
    output logic                          stall_pc,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic [CNT_W-1:0]              stall_cnt
);

    // Wide enough to hold LOAD_LAT-1; at least one bit when LOAD_LAT==1.
    localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    state_t             state_reg, state_next;
    logic [REM_W-1:0]   remaining_reg, remaining_next;
    logic [CNT_W-1:0]   stall_cnt_reg;

    fwd_sel_t           sel_arr [NUM_SRC];
    logic [NUM_SRC-1:0] match_id_ex;
    logic [NUM_SRC-1:0] match_ex_mem;
    logic               haz_load;
    logic               haz_raw;
    logic               haz;
    logic               stall_active;

    // Per-operand forwarding and decode-stage dependency compares.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_select #(
                .REG_ADDR_W (REG_ADDR_W)
            ) u_fwd_select (
                .ars             (ars_id_ex[gi*REG_ADDR_W +: REG_ADDR_W]),
                .ard_ex_mem      (ard_ex_mem),
                .regwrite_ex_mem (regwrite_ex_mem),
                .ard_mem_wb      (ard_mem_wb),
                .regwrite_mem_wb (regwrite_mem_wb),
                .sel             (sel_arr[gi])
            );

            // Without forwarding every operand reads the register file.
            assign forward[gi*2 +: 2] = ((FWD_EN != 0) && rst_n) ? sel_arr[gi] : FWD_RF;

            assign match_id_ex[gi]  = uses_rs_if_id[gi] &&
                                      (ars_if_id[gi*REG_ADDR_W +: REG_ADDR_W] == ard_id_ex);
            assign match_ex_mem[gi] = uses_rs_if_id[gi] &&
                                      (ars_if_id[gi*REG_ADDR_W +: REG_ADDR_W] == ard_ex_mem);
        end
    endgenerate

    assign haz_load = memread_id_ex && (ard_id_ex != '0) && (|match_id_ex);

    // Without forwarding any pending write in EX or MEM is a hazard; WB is
    // assumed to be visible through a write-before-read register file.
    assign haz_raw  = (regwrite_id_ex  && (ard_id_ex  != '0) && (|match_id_ex)) ||
                      (regwrite_ex_mem && (ard_ex_mem != '0) && (|match_ex_mem));

    assign haz = (FWD_EN != 0) ? haz_load : (haz_load || haz_raw);

    // State register and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            if (stall_pc && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    // Next-state logic. The detect cycle in IDLE is the first stall cycle,
    // so STALL only covers the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        if (flush) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (haz && (LOAD_LAT > 1)) begin
                        state_next     = STALL;
                        remaining_next = REM_W'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (remaining_reg <= REM_W'(1)) begin
                        state_next     = IDLE;
                        remaining_next = '0;
                    end else begin
                        remaining_next = remaining_reg - 1'b1;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end
            endcase
        end
    end

    // Output logic. Flush suppresses the stall so the flush path owns the kill.
    always_comb begin
        stall_active = 1'b0;
        if (!flush) begin
            case (state_reg)
                IDLE:    stall_active = haz;
                STALL:   stall_active = 1'b1;
                default: stall_active = 1'b0;
            endcase
        end
    end

    assign stall_pc     = stall_active && rst_n;
    assign stall_if_id  = stall_active && rst_n;
    assign bubble_id_ex = stall_active && rst_n;
    assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int W = 5;
    localparam int N = 2;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] ars_if_id;
    logic [N-1:0]   uses_rs_if_id;
    logic [N*W-1:0] ars_id_ex;
    logic [W-1:0]   ard_id_ex;
    logic           regwrite_id_ex;
    logic           memread_id_ex;
    logic [W-1:0]   ard_ex_mem;
    logic           regwrite_ex_mem;
    logic [W-1:0]   ard_mem_wb;
    logic           regwrite_mem_wb;
    logic           flush;

    // a: defaults (LOAD_LAT=1), b: LOAD_LAT=3, c: FWD_EN=0, d: CNT_W=4
    logic [N*2-1:0] a_forward, b_forward, c_forward, d_forward;
    logic           a_stall_pc, b_stall_pc, c_stall_pc, d_stall_pc;
    logic           a_stall_if_id, b_stall_if_id, c_stall_if_id, d_stall_if_id;
    logic           a_bubble, b_bubble, c_bubble, d_bubble;
    logic [15:0]    a_stall_cnt, b_stall_cnt, c_stall_cnt;
    logic [3:0]     d_stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_forward_unit #(.LOAD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ars_if_id(ars_if_id), .uses_rs_if_id(uses_rs_if_id),
        .ars_id_ex(ars_id_ex), .ard_id_ex(ard_id_ex), .regwrite_id_ex(regwrite_id_ex),
        .memread_id_ex(memread_id_ex), .ard_ex_mem(ard_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .ard_mem_wb(ard_mem_wb), .regwrite_mem_wb(regwrite_mem_wb), .flush(flush),
        .forward(a_forward), .stall_pc(a_stall_pc), .stall_if_id(a_stall_if_id),
        .bubble_id_ex(a_bubble), .stall_cnt(a_stall_cnt)
    );

    hazard_forward_unit #(.LOAD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ars_if_id(ars_if_id), .uses_rs_if_id(uses_rs_if_id),
        .ars_id_ex(ars_id_ex), .ard_id_ex(ard_id_ex), .regwrite_id_ex(regwrite_id_ex),
        .memread_id_ex(memread_id_ex), .ard_ex_mem(ard_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .ard_mem_wb(ard_mem_wb), .regwrite_mem_wb(regwrite_mem_wb), .flush(flush),
        .forward(b_forward), .stall_pc(b_stall_pc), .stall_if_id(b_stall_if_id),
        .bubble_id_ex(b_bubble), .stall_cnt(b_stall_cnt)
    );

    hazard_forward_unit #(.FWD_EN(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .ars_if_id(ars_if_id), .uses_rs_if_id(uses_rs_if_id),
        .ars_id_ex(ars_id_ex), .ard_id_ex(ard_id_ex), .regwrite_id_ex(regwrite_id_ex),
        .memread_id_ex(memread_id_ex), .ard_ex_mem(ard_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .ard_mem_wb(ard_mem_wb), .regwrite_mem_wb(regwrite_mem_wb), .flush(flush),
        .forward(c_forward), .stall_pc(c_stall_pc), .stall_if_id(c_stall_if_id),
        .bubble_id_ex(c_bubble), .stall_cnt(c_stall_cnt)
    );

    hazard_forward_unit #(.CNT_W(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .ars_if_id(ars_if_id), .uses_rs_if_id(uses_rs_if_id),
        .ars_id_ex(ars_id_ex), .ard_id_ex(ard_id_ex), .regwrite_id_ex(regwrite_id_ex),
        .memread_id_ex(memread_id_ex), .ard_ex_mem(ard_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .ard_mem_wb(ard_mem_wb), .regwrite_mem_wb(regwrite_mem_wb), .flush(flush),
        .forward(d_forward), .stall_pc(d_stall_pc), .stall_if_id(d_stall_if_id),
        .bubble_id_ex(d_bubble), .stall_cnt(d_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        ars_if_id       = '0;
        uses_rs_if_id   = '0;
        ars_id_ex       = '0;
        ard_id_ex       = '0;
        regwrite_id_ex  = 1'b0;
        memread_id_ex   = 1'b0;
        ard_ex_mem      = '0;
        regwrite_ex_mem = 1'b0;
        ard_mem_wb      = '0;
        regwrite_mem_wb = 1'b0;
        flush           = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // lw x7 in ID/EX, decode instruction reads x7 as src0.
    task automatic set_load_use;
        ard_id_ex      = 5'd7;
        memread_id_ex  = 1'b1;
        regwrite_id_ex = 1'b1;
        ars_if_id      = {5'd0, 5'd7};
        uses_rs_if_id  = 2'b01;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        set_load_use();
        ars_id_ex       = {5'd5, 5'd5};
        ard_ex_mem      = 5'd5;
        regwrite_ex_mem = 1'b1;
        #1;
        checks++;
        if (a_stall_pc !== 1'b0 || a_stall_if_id !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got pc=%b ifid=%b bub=%b, want 0 0 0", a_stall_pc, a_stall_if_id, a_bubble);
        end
        checks++;
        if (a_forward !== 4'b0000) begin
            errors++;
            $display("FAIL reset_forward: got %b, want 0000", a_forward);
        end
        step();
        checks++;
        if (a_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d, want 0", a_stall_cnt);
        end
        $display("reset: pc=%b fwd=%b cnt=%0d", a_stall_pc, a_forward, a_stall_cnt);
        apply_reset();
    endtask

    task automatic test_forward_both;
        clear_inputs();
        ars_id_ex       = {5'd5, 5'd5};
        ard_ex_mem      = 5'd5;
        regwrite_ex_mem = 1'b1;
        ard_mem_wb      = 5'd5;
        regwrite_mem_wb = 1'b1;
        #1;
        checks++;
        if (a_forward !== 4'b1010) begin
            errors++;
            $display("FAIL fwd_both: got %b, want 1010", a_forward);
        end
        checks++;
        if (c_forward !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_disabled: got %b, want 0000", c_forward);
        end
        $display("fwd_both: fwd=%b nofwd=%b", a_forward, c_forward);
    endtask

    task automatic test_forward_split;
        clear_inputs();
        ars_id_ex       = {5'd4, 5'd3};
        ard_ex_mem      = 5'd4;
        regwrite_ex_mem = 1'b1;
        ard_mem_wb      = 5'd3;
        regwrite_mem_wb = 1'b1;
        #1;
        checks++;
        if (a_forward !== 4'b1001) begin
            errors++;
            $display("FAIL fwd_split: got %b, want 1001", a_forward);
        end
        $display("fwd_split: fwd=%b", a_forward);
        // MEM/WB write disabled: src0 falls back to the register file.
        regwrite_mem_wb = 1'b0;
        #1;
        checks++;
        if (a_forward !== 4'b1000) begin
            errors++;
            $display("FAIL fwd_wb_off: got %b, want 1000", a_forward);
        end
        $display("fwd_wb_off: fwd=%b", a_forward);
        // x0 destinations on both stages are never forwarded.
        ars_id_ex       = {5'd0, 5'd0};
        ard_ex_mem      = 5'd0;
        ard_mem_wb      = 5'd0;
        regwrite_mem_wb = 1'b1;
        #1;
        checks++;
        if (a_forward !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_x0: got %b, want 0000", a_forward);
        end
        $display("fwd_x0: fwd=%b", a_forward);
    endtask

    task automatic test_load_use_lat1;
        apply_reset();
        set_load_use();
        #1;
        checks++;
        if (a_stall_pc !== 1'b1 || a_stall_if_id !== 1'b1 || a_bubble !== 1'b1) begin
            errors++;
            $display("FAIL lat1_detect: got pc=%b ifid=%b bub=%b, want 1 1 1", a_stall_pc, a_stall_if_id, a_bubble);
        end
        checks++;
        if (a_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lat1_cnt_before: got %0d, want 0", a_stall_cnt);
        end
        $display("lat1 detect: pc=%b cnt=%0d", a_stall_pc, a_stall_cnt);
        step();
        // Load has moved on; a bubble now sits in ID/EX.
        clear_inputs();
        ard_ex_mem      = 5'd7;
        regwrite_ex_mem = 1'b1;
        ars_if_id       = {5'd0, 5'd7};
        uses_rs_if_id   = 2'b01;
        #1;
        checks++;
        if (a_stall_pc !== 1'b0 || a_bubble !== 1'b0) begin
            errors++;
            $display("FAIL lat1_release: got pc=%b bub=%b, want 0 0", a_stall_pc, a_bubble);
        end
        checks++;
        if (a_stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lat1_cnt: got %0d, want 1", a_stall_cnt);
        end
        $display("lat1 release: pc=%b cnt=%0d", a_stall_pc, a_stall_cnt);
    endtask

    task automatic test_load_use_lat3;
        apply_reset();
        set_load_use();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (b_stall_pc !== 1'b1 || b_bubble !== 1'b1) begin
                errors++;
                $display("FAIL lat3_stall%0d: got pc=%b bub=%b, want 1 1", k, b_stall_pc, b_bubble);
            end
            $display("lat3 cycle %0d: pc=%b", k, b_stall_pc);
            step();
            clear_inputs();
        end
        #1;
        checks++;
        if (b_stall_pc !== 1'b0 || b_stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL lat3_release: got pc=%b cnt=%0d, want 0 3", b_stall_pc, b_stall_cnt);
        end
        $display("lat3 release: pc=%b cnt=%0d", b_stall_pc, b_stall_cnt);

        // Same hazard, flushed in the second stall cycle.
        apply_reset();
        set_load_use();
        #1;
        checks++;
        if (b_stall_pc !== 1'b1) begin
            errors++;
            $display("FAIL lat3f_detect: got pc=%b, want 1", b_stall_pc);
        end
        step();
        clear_inputs();
        flush = 1'b1;
        #1;
        checks++;
        if (b_stall_pc !== 1'b0 || b_stall_if_id !== 1'b0 || b_bubble !== 1'b0) begin
            errors++;
            $display("FAIL lat3f_flush: got pc=%b ifid=%b bub=%b, want 0 0 0", b_stall_pc, b_stall_if_id, b_bubble);
        end
        $display("lat3 flush: pc=%b bub=%b", b_stall_pc, b_bubble);
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (b_stall_pc !== 1'b0 || b_stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lat3f_after: got pc=%b cnt=%0d, want 0 1", b_stall_pc, b_stall_cnt);
        end
        $display("lat3 after flush: pc=%b cnt=%0d", b_stall_pc, b_stall_cnt);
    endtask

    task automatic test_back_to_back;
        apply_reset();
        set_load_use();
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (b_stall_pc !== 1'b1) begin
                errors++;
                $display("FAIL b2b_stall%0d: got %b, want 1", k, b_stall_pc);
            end
            if (k == 5) clear_inputs();
            step();
        end
        #1;
        checks++;
        if (b_stall_pc !== 1'b0 || b_stall_cnt !== 16'd6) begin
            errors++;
            $display("FAIL b2b_end: got pc=%b cnt=%0d, want 0 6", b_stall_pc, b_stall_cnt);
        end
        $display("back_to_back: pc=%b cnt=%0d", b_stall_pc, b_stall_cnt);
    endtask

    task automatic test_no_forward;
        apply_reset();
        ard_ex_mem      = 5'd9;
        regwrite_ex_mem = 1'b1;
        ars_if_id       = {5'd9, 5'd0};
        uses_rs_if_id   = 2'b10;
        ars_id_ex       = {5'd9, 5'd0};
        #1;
        checks++;
        if (c_stall_pc !== 1'b1 || c_bubble !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_stall: got pc=%b bub=%b, want 1 1", c_stall_pc, c_bubble);
        end
        checks++;
        if (c_forward !== 4'b0000) begin
            errors++;
            $display("FAIL nofwd_forward: got %b, want 0000", c_forward);
        end
        checks++;
        if (a_stall_pc !== 1'b0 || a_forward !== 4'b1000) begin
            errors++;
            $display("FAIL fwd_ex_mem_nostall: got pc=%b fwd=%b, want 0 1000", a_stall_pc, a_forward);
        end
        $display("nofwd: stall=%b fwd=%b | fwd unit: stall=%b fwd=%b", c_stall_pc, c_forward, a_stall_pc, a_forward);
        uses_rs_if_id = 2'b00;
        #1;
        checks++;
        if (c_stall_pc !== 1'b0) begin
            errors++;
            $display("FAIL nofwd_unused: got %b, want 0", c_stall_pc);
        end
        $display("nofwd unused src: stall=%b", c_stall_pc);
        // Non-load producer still in ID/EX also stalls without forwarding.
        clear_inputs();
        ard_id_ex      = 5'd12;
        regwrite_id_ex = 1'b1;
        ars_if_id      = {5'd0, 5'd12};
        uses_rs_if_id  = 2'b01;
        #1;
        checks++;
        if (c_stall_pc !== 1'b1 || a_stall_pc !== 1'b0) begin
            errors++;
            $display("FAIL nofwd_idex: got nofwd=%b fwd=%b, want 1 0", c_stall_pc, a_stall_pc);
        end
        $display("nofwd id/ex alu: nofwd=%b fwd=%b", c_stall_pc, a_stall_pc);
    endtask

    task automatic test_reset_mid_stall;
        apply_reset();
        set_load_use();
        step();
        clear_inputs();
        step();
        #1;
        checks++;
        if (b_stall_pc !== 1'b1 || b_stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL mid_pre: got pc=%b cnt=%0d, want 1 2", b_stall_pc, b_stall_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_stall_pc !== 1'b0 || b_bubble !== 1'b0 || b_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got pc=%b bub=%b cnt=%0d, want 0 0 0", b_stall_pc, b_bubble, b_stall_cnt);
        end
        $display("reset mid-stall: pc=%b cnt=%0d", b_stall_pc, b_stall_cnt);
        rst_n = 1'b1;
        step();
        checks++;
        if (b_stall_pc !== 1'b0 || b_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_idle: got pc=%b cnt=%0d, want 0 0", b_stall_pc, b_stall_cnt);
        end
        $display("after reset: pc=%b cnt=%0d", b_stall_pc, b_stall_cnt);
    endtask

    task automatic test_saturation;
        apply_reset();
        set_load_use();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 15) begin
                checks++;
                if (d_stall_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_15: got %0d, want 15", d_stall_cnt);
                end
                $display("sat after 15: cnt=%0d", d_stall_cnt);
            end
        end
        checks++;
        if (d_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d, want 15", d_stall_cnt);
        end
        checks++;
        if (a_stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL cnt_wide: got %0d, want 20", a_stall_cnt);
        end
        $display("sat after 20: cnt4=%0d cnt16=%0d", d_stall_cnt, a_stall_cnt);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forward_both();
        test_forward_split();
        test_load_use_lat1();
        test_load_use_lat3();
        test_back_to_back();
        test_no_forward();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline forwarding logic for the 5-stage RISC-V core. Combines three functions:
  - per-source-operand forwarding select;
  - load-use hazard detection with a configurable multi-cycle stall sequencer;
  - a saturating stall-cycle performance counter.
- Sits beside the ID/EX register. Drives the EX operand muxes, the IF/ID and PC hold enables, and the ID/EX bubble insert.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands checked (3 for future R4-type).
- LOAD_LAT, 1, stall cycles per load-use hazard; must be ≥1.
- FWD_EN, 1, forwarding mode. 1 = forward. 0 = no forwarding; stall on any RAW hazard.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- ARS_IF_ID  in  NUM_SRC*REG_ADDR_W  decode-stage source addresses; src i at slice [i*REG_ADDR_W +: REG_ADDR_W]
- USES_RS_IF_ID  in  NUM_SRC  decode-stage source valid per operand
- ARS_ID_EX  in  NUM_SRC*REG_ADDR_W  EX-stage source addresses
- ARD_ID_EX  in  REG_ADDR_W  EX-stage destination
- REGWRITE_ID_EX, MEMREAD_ID_EX  in  1  EX-stage control
- ARD_EX_MEM  in  REG_ADDR_W  MEM-stage destination
- REGWRITE_EX_MEM  in  1  MEM-stage control
- ARD_MEM_WB  in  REG_ADDR_W  WB-stage destination
- REGWRITE_MEM_WB  in  1  WB-stage control
- FLUSH  in  1  branch/jump taken; kill IF/ID
- FORWARD  out  NUM_SRC*2  per-operand select: 00 register file, 10 EX/MEM, 01 MEM/WB
- STALL_PC, STALL_IF_ID  out  1  hold enables
- BUBBLE_ID_EX  out  1  insert NOP into ID/EX
- STALL_CNT  out  CNT_W  total stall cycles, saturating

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, remaining=0, STALL_CNT=0.
  - All outputs 0 while RST_N low.
- Forwarding (combinational; FWD_EN=1):
  - Each operand is evaluated independently; no cross-operand priority.
  - Src i: 10 if REGWRITE_EX_MEM && ARD_EX_MEM!=0 && ARD_EX_MEM==ARS_ID_EX[i].
  - Otherwise 01 if REGWRITE_MEM_WB && ARD_MEM_WB!=0 && ARD_MEM_WB==ARS_ID_EX[i].
  - Otherwise 00.
  - x0 is never forwarded.
- FWD_EN=0: FORWARD is tied to 0.
- Hazard detection (combinational):
  - FWD_EN=1: HAZ = MEMREAD_ID_EX && ARD_ID_EX!=0 && any i with USES_RS_IF_ID[i] && ARS_IF_ID[i]==ARD_ID_EX.
  - FWD_EN=0: HAZ additionally covers ID/EX and EX/MEM destinations with REGWRITE set, load or not.
- Sequencer states:
  - IDLE: if HAZ && !FLUSH, assert the stall outputs this cycle (zero-latency detect). Then go to STALL with remaining=LOAD_LAT-1 if LOAD_LAT>1, otherwise stay IDLE.
  - STALL: stall outputs are asserted unconditionally. remaining decrements each cycle; at remaining==1, return to IDLE next cycle. HAZ is ignored in STALL. On return to IDLE, HAZ is re-evaluated, so back-to-back hazards chain.
  - Stall outputs means STALL_PC=STALL_IF_ID=BUBBLE_ID_EX=1.
- FLUSH:
  - In any state, FLUSH has priority. Stall outputs are 0 that cycle and the state goes to IDLE with remaining=0.
  - BUBBLE_ID_EX stays 0; the flush path owns the kill.
- Total stall length per isolated load-use = exactly LOAD_LAT cycles.
- STALL_CNT:
  - Increments every cycle in which STALL_PC=1.
  - Holds at all-ones; no wrap.
- All address widths derive from REG_ADDR_W. No arithmetic beyond the counter decrement and the saturating increment.

Decomposition:
- Package hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10) and state_t (IDLE, STALL).
- One sub-module, fwd_select: a single-operand comparator returning fwd_sel_t, instantiated NUM_SRC times via a generate loop.

Test Plan:
- Forwarding, both operands: ARS_ID_EX = {x5, x5}, EX/MEM rd=x5 wr=1, MEM/WB rd=x5 wr=1 -> FORWARD={10,10}. Both sources are set at once, and EX/MEM beats MEM/WB.
- Split forwarding and x0:
  - rs1=x3 matches MEM/WB only, rs2=x4 matches EX/MEM -> {01 for rs1, 10 for rs2}.
  - rd=x0 with wr=1 on both stages -> 00.
- Load-use, LOAD_LAT=1: lw x7 in ID/EX, decode add uses x7 -> stall outputs high exactly 1 cycle (the detect cycle); STALL_CNT 0->1.
- Load-use, LOAD_LAT=3, with FLUSH:
  - Stall held for 3 cycles, then released.
  - Repeat with FLUSH in the 2nd stall cycle -> outputs drop that cycle, state IDLE, STALL_CNT=1.
- FWD_EN=0: non-load add x9 in EX/MEM, decode uses x9 -> stall asserted and FORWARD=0. Same case with USES_RS_IF_ID=0 -> no stall.
- Reset and saturation:
  - RST_N low mid-STALL -> outputs 0 immediately and STALL_CNT=0.
  - CNT_W=4 with 20 forced stall cycles -> STALL_CNT holds at 15.
